// File: rtl/minisys_io_pkg.sv
// minisys_io_pkg: FSM states, active-low 7-seg code table and decode helpers
package minisys_io_pkg;
  typedef enum logic [1:0] {HOLD, IDLE, APPLY} state_t;
  localparam logic [7:0] SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  function automatic logic seg_known(input logic [7:0] p);
    seg_known = 1'b0;
    for (int k = 0; k < 16; k++) if (p[6:0] == SEG_HEX[k][6:0]) seg_known = 1'b1;
  endfunction
  function automatic logic [3:0] seg_hex(input logic [7:0] p);
    seg_hex = 4'h0;
    for (int k = 0; k < 16; k++) if (p[6:0] == SEG_HEX[k][6:0]) seg_hex = 4'(k);
  endfunction
endpackage

// File: rtl/minisys_sw_fifo.sv
// minisys_sw_fifo: synchronous FIFO, head visible on dout with no read latency
module minisys_sw_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
endmodule

// File: rtl/minisys_io_harness.sv
// minisys_io_harness: core reset stretch, queued switch playback, LED change count and tube capture
// Optional TUBE_DECODE_EN adds digit_hex/decode_err outputs.
module minisys_io_harness import minisys_io_pkg::*; #(
  parameter int SW_W     = 24,
  parameter int LED_W    = 24,
  parameter int DIGITS   = 8,
  parameter int RST_HOLD = 350,
  parameter int DWELL    = 1000,
  parameter int DEPTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  core_rst,
  input  logic                  sw_push,
  input  logic [SW_W-1:0]       sw_push_data,
  output logic                  sw_full,
  output logic                  sw_busy,
  output logic [SW_W-1:0]       switch_out,
  input  logic [LED_W-1:0]      led_in,
  output logic [15:0]           led_change_cnt,
  input  logic [7:0]            tube_data,
  input  logic [DIGITS-1:0]     tube_addr,
  output logic [8*DIGITS-1:0]   digit_shadow,
  output logic                  scan_done
`ifdef TUBE_DECODE_EN
  ,
  output logic [4*DIGITS-1:0]   digit_hex,
  output logic                  decode_err
`endif
);
  localparam int HW = $clog2(RST_HOLD + 2);
  localparam int DW = $clog2(DWELL + 1);
  state_t state, state_nx;
  logic [HW-1:0] hold_cnt;
  logic [DW-1:0] dwell;
  logic [SW_W-1:0] head;
  logic fifo_empty, pop, last;
  logic [LED_W-1:0] led_prev;
  logic [DIGITS-1:0] sel, hit, visited, vis_nx;
  minisys_sw_fifo #(.WIDTH(SW_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(sw_push), .pop(pop), .din(sw_push_data),
    .dout(head), .full(sw_full), .empty(fifo_empty)
  );
  assign last = dwell == DW'(DWELL - 1);
  assign core_rst = state == HOLD;
  assign sw_busy = state == APPLY || !fifo_empty;
  always_comb begin
    pop = (state == IDLE || (state == APPLY && last)) && !fifo_empty;
    state_nx = state == HOLD ? (hold_cnt == HW'(RST_HOLD) ? IDLE : HOLD)
             : state == IDLE ? (fifo_empty ? IDLE : APPLY)
             : (last && fifo_empty ? IDLE : APPLY);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HOLD;
      hold_cnt <= '0;
      dwell <= '0;
      switch_out <= '0;
    end else begin
      state <= state_nx;
      if (state == HOLD) hold_cnt <= hold_cnt + HW'(1);
      dwell <= (pop || state != APPLY) ? '0 : dwell + DW'(1);
      if (pop) switch_out <= head;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      led_prev <= '0;
      led_change_cnt <= '0;
    end else begin
      led_prev <= led_in;
      if (!core_rst && led_in != led_prev && led_change_cnt != 16'hFFFF)
        led_change_cnt <= led_change_cnt + 16'd1;
    end
  end
  // A legal select drives exactly one digit line low
  assign sel = ~tube_addr;
  assign hit = $onehot(sel) ? sel : '0;
  assign vis_nx = visited | hit;
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_shadow <= '1;
      visited <= '0;
      scan_done <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) if (hit[i]) digit_shadow[8*i +: 8] <= tube_data;
      scan_done <= &vis_nx;
      visited <= &vis_nx ? '0 : vis_nx;
    end
  end
`ifdef TUBE_DECODE_EN
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    assign digit_hex[4*g +: 4] = seg_hex(digit_shadow[8*g +: 8]);
  end
  // Only captured patterns can flag an error, so the blank reset shadow does not
  always_ff @(posedge clk) begin
    if (rst) decode_err <= 1'b0;
    else if (|hit && !seg_known(tube_data)) decode_err <= 1'b1;
  end
`endif
endmodule
